// File: rtl/control_sumador_nibble_pkg.sv
// rtl/control_sumador_nibble_pkg.sv - shared types and helpers for the nibble-serial adder
package pkg_sumador;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUMA  = 2'd1,
    LISTO = 2'd2
  } estado_t;

  localparam int NIBBLE_W = 4;

  // Ceiling log2, used to size the nibble counter.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sumador_nibble.sv
// rtl/sumador_nibble.sv - 4-bit combinational ripple adder with carry in/out
module sumador_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  // Plain 5-bit sum; the top bit is the nibble carry-out.
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  end

endmodule

// File: rtl/control_sumador_nibble.sv
// rtl/control_sumador_nibble.sv - W-bit add/subtract sequenced one nibble per clock
module control_sumador_nibble
  import pkg_sumador::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  input  logic         resta,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] suma,
  output logic         co,
  output logic         ov,
  output logic         ocupado
);

  localparam int NIB = W / NIBBLE_W;
  localparam int CW  = (clog2(NIB) < 1) ? 1 : clog2(NIB);

  if ((W % NIBBLE_W) != 0 || W < NIBBLE_W) begin : g_w_invalid
    $error("control_sumador_nibble: W must be a multiple of 4 and >= 4");
  end

  estado_t                estado_q, estado_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   carry_q, carry_d;
  logic [NIB-1:0][3:0]    a_q, a_d;
  logic [NIB-1:0][3:0]    b_q, b_d;
  logic [NIB-1:0][3:0]    suma_q, suma_d;
  logic                   co_q, co_d;
  logic                   ov_q, ov_d;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] s_nib;
  logic       c4;
  logic       ultimo;

  // The single shared adder sees the nibble selected by the counter.
  assign a_nib  = a_q[cnt_q];
  assign b_nib  = b_q[cnt_q];
  assign ultimo = (cnt_q == CW'(NIB - 1));

  sumador_nibble u_nibble (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (c4)
  );

  // Next-state logic: accept operands, ripple one nibble per cycle, hold result until taken.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    suma_d   = suma_q;
    co_d     = co_q;
    ov_d     = ov_q;
    case (estado_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so ci only matters for addition.
          a_d      = a;
          b_d      = resta ? ~b : b;
          carry_d  = resta ? 1'b1 : ci;
          suma_d   = '0;
          cnt_d    = '0;
          estado_d = SUMA;
        end
      end
      SUMA: begin
        suma_d[cnt_q] = s_nib;
        carry_d       = c4;
        if (ultimo) begin
          co_d     = c4;
          ov_d     = (a_q[NIB-1][3] == b_q[NIB-1][3]) && (s_nib[3] != a_q[NIB-1][3]);
          cnt_d    = '0;
          estado_d = LISTO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LISTO: begin
        if (out_ready) begin
          estado_d = IDLE;
        end
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      suma_q   <= '0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      suma_q   <= suma_d;
      co_q     <= co_d;
      ov_q     <= ov_d;
    end
  end

  assign suma      = suma_q;
  assign co        = co_q;
  assign ov        = ov_q;
  assign in_ready  = (estado_q == IDLE);
  assign out_valid = (estado_q == LISTO);
  assign ocupado   = (estado_q != IDLE);

endmodule
